led_channel_ctrl: RTL and testbench
===================================

Name: led_channel_ctrl

Overview:
- Parametrised multi-channel LED controller; successor to the single fixed-rate on-chip blinker.
- Per channel: mode OFF, ON, BLINK (programmable half-period) or PWM (programmable duty).
- A shared prescaler makes a slow tick that times all BLINK channels.
- A simple one-cycle write port configures the channels; top level drives board LED pins directly from led.

Parameters:
- CHANNELS, 4, number of LED outputs (1..16).
- ADDR_WIDTH, 2, channel-select width; must satisfy 2^ADDR_WIDTH >= CHANNELS.
- PRESCALE, 48000, clk cycles per tick (>=2); default gives 1 kHz from 48 MHz.
- CNT_WIDTH, 16, width of half-period registers and blink counters.
- PWM_WIDTH, 8, width of duty registers and the shared PWM counter.
- DEFAULT_HALF, 500, reset half-period in ticks; default gives 1 Hz blink.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- cfg_we  in  1  write strobe; acts on one cycle per asserted clk edge.
- cfg_addr  in  ADDR_WIDTH  channel index.
- cfg_field  in  2  target field: 0=mode (wdata[1:0]: 0 OFF, 1 ON, 2 BLINK, 3 PWM), 1=half-period, 2=duty, 3=reserved.
- cfg_wdata  in  CNT_WIDTH  write data; duty uses the low PWM_WIDTH bits.
- tick  out  1  one-cycle prescaler pulse, for debug and other blocks.
- led  out  CHANNELS  registered LED drive, 1 = lit.

Behaviour:
- Reset, sampled on a clk edge with reset=1, applies to all channels:
  - mode=BLINK, half=DEFAULT_HALF, duty=0.
  - Blink counter=0, blink phase=1.
  - Prescaler=0, PWM counter=0.
  - tick=0, led=all ones.
- Reset has priority over cfg_we. Reset mid-blink or mid-write loses all state; the next cycle is as if from power-up.
- Prescaler:
  - Counts 0..PRESCALE-1, then wraps to 0.
  - tick is registered: high for exactly the one cycle after the count reaches PRESCALE-1, so its period is PRESCALE cycles.
- PWM counter:
  - Free-running PWM_WIDTH-bit counter; increments every clk and wraps naturally.
- Config writes:
  - On a clk edge with cfg_we=1, the addressed field updates.
  - cfg_addr >= CHANNELS or cfg_field=3: write ignored, no state changes.
- Mode write:
  - Clears that channel's blink counter and sets blink phase=1, even if the mode is unchanged.
- Half-period write:
  - Clears the blink counter; phase is kept.
  - A value of 0 is treated as 1.
- BLINK channel:
  - On each tick, if counter >= max(half,1)-1: phase toggles and counter clears.
  - Otherwise the counter increments.
  - Result: phase toggles every max(half,1) ticks.
- Non-BLINK channels hold counter and phase frozen.
- led per channel, registered:
  - OFF: 0.
  - ON: 1.
  - BLINK: phase.
  - PWM: (pwm_cnt < duty). duty=0 gives always 0; duty=2^PWM_WIDTH-1 gives high 255 of 256 cycles at default width.
- Latency:
  - A config write at edge k changes the internal field at edge k.
  - led reflects the new field at edge k+1.
  - A tick-driven phase toggle appears on led one edge after the toggle.
- Simultaneous write and tick to the same channel: the write wins, and the tick's counter/phase update for that channel is discarded.
- Other channels are unaffected by any write.
- All widths are unsigned. Counter comparisons are done at CNT_WIDTH with no overflow; the counter never exceeds half-1.

Test Plan (CHANNELS=4, PRESCALE=4, DEFAULT_HALF=3 unless noted):
- Reset 2 cycles then release:
  - led=4'b1111.
  - tick pulses every 4 cycles.
  - All channels toggle every 3 ticks (12 cycles); first toggle to 0 follows the third tick after reset.
- Write ch1 mode=OFF, ch2 mode=ON: one cycle later led[1]=0 and led[2]=1, held for 100 cycles. ch0 and ch3 keep blinking in phase.
- ch3 mode=PWM with duty=64, 1024 cycles observed: led[3] high exactly 256 cycles. duty=0 gives 0 high cycles; duty=255 gives 1020.
- ch0 half=0: led[0] toggles every tick (4 cycles). Then half=5: toggles every 20 cycles, counted from the write.
- Mode write to ch0 issued on the same cycle as a tick:
  - The write wins: counter=0, phase=1, no toggle from that tick.
  - Next toggle is 3 ticks later.
- Write with cfg_addr=4 (ADDR_WIDTH=3) and with cfg_field=3: no led or timing change on any channel.
- reset asserted mid-PWM with cfg_we=1 on the same edge: next cycle led=4'b1111, all channels in BLINK, and the write is not applied.

Source files
------------

// File: rtl/led_channel_ctrl.sv
// Multi-channel LED controller: per-channel OFF/ON/BLINK/PWM with a shared tick prescaler
// and a one-cycle configuration write port.
module led_channel_ctrl #(
  parameter int unsigned CHANNELS     = 4,
  parameter int unsigned ADDR_WIDTH   = 2,
  parameter int unsigned PRESCALE     = 48000,
  parameter int unsigned CNT_WIDTH    = 16,
  parameter int unsigned PWM_WIDTH    = 8,
  parameter int unsigned DEFAULT_HALF = 500
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cfg_we,
  input  logic [ADDR_WIDTH-1:0] cfg_addr,
  input  logic [1:0]            cfg_field,
  input  logic [CNT_WIDTH-1:0]  cfg_wdata,
  output logic                  tick,
  output logic [CHANNELS-1:0]   led
);

  localparam int unsigned PsWidth = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  typedef enum logic [1:0] {
    ModeOff   = 2'd0,
    ModeOn    = 2'd1,
    ModeBlink = 2'd2,
    ModePwm   = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    FieldMode = 2'd0,
    FieldHalf = 2'd1,
    FieldDuty = 2'd2,
    FieldRsvd = 2'd3
  } field_e;

  logic [PsWidth-1:0]   presc_q, presc_d;
  logic                 tick_q, tick_d;
  logic [PWM_WIDTH-1:0] pwm_q, pwm_d;
  logic [CHANNELS-1:0]  led_q, led_d;

  mode_e                mode_q  [CHANNELS];
  mode_e                mode_d  [CHANNELS];
  logic [CNT_WIDTH-1:0] half_q  [CHANNELS];
  logic [CNT_WIDTH-1:0] half_d  [CHANNELS];
  logic [PWM_WIDTH-1:0] duty_q  [CHANNELS];
  logic [PWM_WIDTH-1:0] duty_d  [CHANNELS];
  logic [CNT_WIDTH-1:0] cnt_q   [CHANNELS];
  logic [CNT_WIDTH-1:0] cnt_d   [CHANNELS];
  logic                 phase_q [CHANNELS];
  logic                 phase_d [CHANNELS];

  logic [31:0]          addr_ext;
  logic                 wr_valid;
  logic [CHANNELS-1:0]  wr_hit;

  // Terminal count for a blink channel; a half-period of 0 behaves as 1.
  function automatic logic [CNT_WIDTH-1:0] blink_last(input logic [CNT_WIDTH-1:0] half);
    logic [CNT_WIDTH-1:0] eff;
    eff = (half == '0) ? CNT_WIDTH'(1) : half;
    return eff - CNT_WIDTH'(1);
  endfunction

  assign tick = tick_q;
  assign led  = led_q;

  // Shared prescaler and PWM counter
  always_comb begin
    tick_d  = (presc_q == PsWidth'(PRESCALE - 1));
    presc_d = tick_d ? '0 : presc_q + PsWidth'(1);
    pwm_d   = pwm_q + PWM_WIDTH'(1);
  end

  // Write decode: out-of-range addresses and the reserved field are dropped entirely
  always_comb begin
    addr_ext = 32'(cfg_addr);
    wr_valid = cfg_we && (addr_ext < CHANNELS) && (field_e'(cfg_field) != FieldRsvd);
    wr_hit   = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      wr_hit[i] = wr_valid && (addr_ext == i);
    end
  end

  // Per-channel next state; a write to a channel overrides that channel's tick update
  always_comb begin
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      mode_d[i]  = mode_q[i];
      half_d[i]  = half_q[i];
      duty_d[i]  = duty_q[i];
      cnt_d[i]   = cnt_q[i];
      phase_d[i] = phase_q[i];

      if (wr_hit[i]) begin
        unique case (field_e'(cfg_field))
          FieldMode: begin
            mode_d[i]  = mode_e'(cfg_wdata[1:0]);
            cnt_d[i]   = '0;
            phase_d[i] = 1'b1;
          end
          FieldHalf: begin
            half_d[i] = (cfg_wdata == '0) ? CNT_WIDTH'(1) : cfg_wdata;
            cnt_d[i]  = '0;
          end
          FieldDuty: begin
            duty_d[i] = cfg_wdata[PWM_WIDTH-1:0];
          end
          default: ;
        endcase
      end else if (tick_q && (mode_q[i] == ModeBlink)) begin
        if (cnt_q[i] >= blink_last(half_q[i])) begin
          cnt_d[i]   = '0;
          phase_d[i] = ~phase_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
        end
      end
    end
  end

  // LED drive is computed from current state, so config changes show one edge later
  always_comb begin
    led_d = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      unique case (mode_q[i])
        ModeOff:   led_d[i] = 1'b0;
        ModeOn:    led_d[i] = 1'b1;
        ModeBlink: led_d[i] = phase_q[i];
        ModePwm:   led_d[i] = (pwm_q < duty_q[i]);
        default:   led_d[i] = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q <= '0;
      tick_q  <= 1'b0;
      pwm_q   <= '0;
      led_q   <= '1;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        mode_q[i]  <= ModeBlink;
        half_q[i]  <= CNT_WIDTH'(DEFAULT_HALF);
        duty_q[i]  <= '0;
        cnt_q[i]   <= '0;
        phase_q[i] <= 1'b1;
      end
    end else begin
      presc_q <= presc_d;
      tick_q  <= tick_d;
      pwm_q   <= pwm_d;
      led_q   <= led_d;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        mode_q[i]  <= mode_d[i];
        half_q[i]  <= half_d[i];
        duty_q[i]  <= duty_d[i];
        cnt_q[i]   <= cnt_d[i];
        phase_q[i] <= phase_d[i];
      end
    end
  end

endmodule

// File: tb/tb_led_channel_ctrl.sv
// Self-checking bench for led_channel_ctrl: directed scenarios plus random config traffic,
// all checked against a behavioural model of the channel rules.
module tb_led_channel_ctrl;

  localparam int CH = 4;
  localparam int AW = 3;
  localparam int PS = 4;
  localparam int DH = 3;
  localparam int PWMW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cfg_we = 1'b0;
  logic [AW-1:0] cfg_addr = '0;
  logic [1:0]    cfg_field = '0;
  logic [15:0]   cfg_wdata = '0;
  logic          tick;
  logic [CH-1:0] led;

  int n_chk = 0;
  int n_fail = 0;

  // Model state: 0 OFF, 1 ON, 2 BLINK, 3 PWM
  int       m_mode[CH], m_half[CH], m_duty[CH], m_cnt[CH], m_phase[CH];
  int       m_presc, m_pwm;
  bit       m_tick;
  bit [3:0] m_led;

  led_channel_ctrl #(
    .CHANNELS    (CH),
    .ADDR_WIDTH  (AW),
    .PRESCALE    (PS),
    .CNT_WIDTH   (16),
    .PWM_WIDTH   (PWMW),
    .DEFAULT_HALF(DH)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .cfg_we   (cfg_we),
    .cfg_addr (cfg_addr),
    .cfg_field(cfg_field),
    .cfg_wdata(cfg_wdata),
    .tick     (tick),
    .led      (led)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One clock edge: advance the model with the inputs presented, then sample 1 time unit later
  task automatic cycle();
    bit [3:0] nled;
    bit       wr;
    int       a, h;
    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < CH; i++) begin
        m_mode[i] = 2; m_half[i] = DH; m_duty[i] = 0; m_cnt[i] = 0; m_phase[i] = 1;
      end
      m_presc = 0; m_pwm = 0; m_tick = 0; m_led = 4'hF;
    end else begin
      for (int i = 0; i < CH; i++) begin
        case (m_mode[i])
          0: nled[i] = 1'b0;
          1: nled[i] = 1'b1;
          2: nled[i] = m_phase[i][0];
          default: nled[i] = (m_pwm < m_duty[i]);
        endcase
      end
      a  = int'(cfg_addr);
      wr = cfg_we && (a < CH) && (cfg_field != 2'd3);
      for (int i = 0; i < CH; i++) begin
        if (m_tick && m_mode[i] == 2 && !(wr && a == i)) begin
          h = (m_half[i] < 1) ? 1 : m_half[i];
          if (m_cnt[i] >= h - 1) begin
            m_phase[i] = 1 - m_phase[i];
            m_cnt[i]   = 0;
          end else begin
            m_cnt[i]++;
          end
        end
      end
      if (wr) begin
        case (cfg_field)
          2'd0: begin m_mode[a] = int'(cfg_wdata) % 4; m_cnt[a] = 0; m_phase[a] = 1; end
          2'd1: begin m_half[a] = (cfg_wdata == 0) ? 1 : int'(cfg_wdata); m_cnt[a] = 0; end
          default: m_duty[a] = int'(cfg_wdata) % (1 << PWMW);
        endcase
      end
      m_tick  = (m_presc == PS - 1);
      m_presc = (m_presc + 1) % PS;
      m_pwm   = (m_pwm + 1) % (1 << PWMW);
      m_led   = nled;
    end
    #1;
  endtask

  task automatic write(input int a, input int f, input int d);
    cfg_we = 1'b1; cfg_addr = AW'(a); cfg_field = 2'(f); cfg_wdata = 16'(d);
    cycle();
    cfg_we = 1'b0;
  endtask

  // Cycles until led[ch] changes; -1 if it does not within lim cycles
  task automatic wait_toggle(input int ch, input int lim, output int n);
    logic start;
    start = led[ch];
    n = -1;
    for (int k = 1; k <= lim; k++) begin
      cycle();
      if (led[ch] !== start) begin
        n = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int ticks, first;
    reset = 1'b1;
    cycle();
    cycle();
    reset = 1'b0;
    n_chk++;
    if (led !== 4'hF) begin n_fail++; $display("FAIL reset_led: got %b want 1111", led); end
    n_chk++;
    if (tick !== 1'b0) begin n_fail++; $display("FAIL reset_tick: got %b want 0", tick); end
    ticks = 0;
    first = 0;
    for (int e = 1; e <= 60; e++) begin
      cycle();
      n_chk++;
      if (led !== m_led || tick !== m_tick) begin
        n_fail++;
        $display("FAIL reset_run e=%0d: led %b tick %b want led %b tick %b", e, led, tick, m_led,
                 m_tick);
      end
      if (tick === 1'b1) ticks++;
      if (first == 0 && led !== 4'hF) begin
        first = e;
        n_chk++;
        if (led !== 4'h0) begin n_fail++; $display("FAIL first_toggle_val: got %b want 0000", led); end
      end
    end
    n_chk++;
    if (ticks != 15) begin n_fail++; $display("FAIL tick_count: got %0d want 15", ticks); end
    n_chk++;
    if (first != 14) begin n_fail++; $display("FAIL first_toggle_edge: got %0d want 14", first); end
  endtask

  task automatic test_modes();
    write(1, 0, 0);
    write(2, 0, 1);
    for (int e = 0; e < 100; e++) begin
      cycle();
      n_chk++;
      if (led[1] !== 1'b0 || led[2] !== 1'b1 || led[0] !== led[3] || led !== m_led) begin
        n_fail++;
        $display("FAIL modes e=%0d: led %b want %b", e, led, m_led);
      end
    end
  endtask

  task automatic test_pwm();
    int duties[3] = '{64, 0, 255};
    int highs;
    write(3, 0, 3);
    foreach (duties[j]) begin
      write(3, 2, duties[j]);
      highs = 0;
      for (int e = 0; e < 1024; e++) begin
        cycle();
        if (led[3] === 1'b1) highs++;
        if (led !== m_led) begin
          n_chk++; n_fail++;
          $display("FAIL pwm_led duty=%0d e=%0d: led %b want %b", duties[j], e, led, m_led);
        end
      end
      n_chk++;
      if (highs != duties[j] * 4) begin
        n_fail++;
        $display("FAIL pwm_high duty=%0d: got %0d want %0d", duties[j], highs, duties[j] * 4);
      end
    end
  endtask

  task automatic test_half();
    int n;
    write(0, 1, 0);
    wait_toggle(0, 20, n);
    wait_toggle(0, 20, n);
    n_chk++;
    if (n != 4) begin n_fail++; $display("FAIL half0_period: got %0d want 4", n); end
    write(0, 1, 5);
    wait_toggle(0, 40, n);
    wait_toggle(0, 40, n);
    n_chk++;
    if (n != 20) begin n_fail++; $display("FAIL half5_period: got %0d want 20", n); end
    n_chk++;
    if (led !== m_led) begin n_fail++; $display("FAIL half_led: got %b want %b", led, m_led); end
  endtask

  task automatic test_collision();
    int guard, first;
    write(0, 1, 3);
    guard = 0;
    while (tick !== 1'b1 && guard < 10) begin
      cycle();
      guard++;
    end
    n_chk++;
    if (tick !== 1'b1) begin n_fail++; $display("FAIL collide_tick: got %b want 1", tick); end
    write(0, 0, 2);
    first = 0;
    for (int e = 1; e <= 30; e++) begin
      cycle();
      if (led !== m_led) begin
        n_chk++; n_fail++;
        $display("FAIL collide_led e=%0d: led %b want %b", e, led, m_led);
      end
      if (first == 0 && led[0] === 1'b0) first = e;
    end
    n_chk++;
    if (first != 13) begin n_fail++; $display("FAIL collide_toggle: got %0d want 13", first); end
  endtask

  task automatic test_ignored();
    write(4, 0, 0);
    write(0, 3, 0);
    write(7, 1, 1);
    write(2, 3, 0);
    for (int e = 0; e < 40; e++) begin
      cycle();
      n_chk++;
      if (led !== m_led || tick !== m_tick) begin
        n_fail++;
        $display("FAIL ignored e=%0d: led %b tick %b want led %b tick %b", e, led, tick, m_led,
                 m_tick);
      end
    end
  endtask

  task automatic test_reset_mid();
    write(3, 0, 3);
    write(3, 2, 128);
    for (int e = 0; e < 20; e++) cycle();
    reset = 1'b1;
    cfg_we = 1'b1; cfg_addr = 3'd0; cfg_field = 2'd0; cfg_wdata = 16'd0;
    cycle();
    reset = 1'b0;
    cfg_we = 1'b0;
    n_chk++;
    if (led !== 4'hF) begin n_fail++; $display("FAIL rst_mid_led: got %b want 1111", led); end
    for (int e = 1; e <= 40; e++) begin
      cycle();
      n_chk++;
      if (led !== m_led || (led !== 4'hF && led !== 4'h0)) begin
        n_fail++;
        $display("FAIL rst_mid_run e=%0d: led %b want %b", e, led, m_led);
      end
    end
  endtask

  task automatic test_random();
    for (int e = 0; e < 1500; e++) begin
      reset  = ($urandom_range(0, 299) == 0);
      cfg_we = ($urandom_range(0, 5) == 0);
      cfg_addr  = AW'($urandom_range(0, 7));
      cfg_field = 2'($urandom_range(0, 3));
      cfg_wdata = (cfg_field == 2'd1) ? 16'($urandom_range(0, 6)) : 16'($urandom);
      cycle();
      n_chk++;
      if (led !== m_led || tick !== m_tick) begin
        n_fail++;
        $display("FAIL random e=%0d: led %b tick %b want led %b tick %b", e, led, tick, m_led,
                 m_tick);
      end
    end
    reset = 1'b0;
    cfg_we = 1'b0;
  endtask

  initial begin
    test_reset();
    test_modes();
    test_pwm();
    test_half();
    test_collision();
    test_ignored();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
